// File: rtl/dp_seq_pkg.sv
// Shared encodings for the datapath sequencer: FSM states, instruction
// classes, sub-operations, write-back source selects and routing helpers.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_CMP       = 3'd5,
    S_WRITE_C   = 3'd6,
    S_WRITE_IMM = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // First state after DECODE; S_WAIT doubles as the undefined-instruction exit.
  function automatic state_t decode_route(input logic [2:0] opcode, input logic [1:0] op);
    state_t nxt;
    nxt = S_WAIT;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      nxt = S_WRITE_IMM;
      else if (op == OP_MOV_REG) nxt = S_GET_B;
    end else if (opcode == OPC_ALU) begin
      if (op == OP_MVN) nxt = S_GET_B;
      else              nxt = S_GET_A;
    end
    return nxt;
  endfunction

  function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
    return decode_route(opcode, op) != S_WAIT;
  endfunction

  // MOV reg and MVN pass only the B operand through the ALU, so A is forced to 0.
  function automatic logic a_is_zero(input logic [2:0] opcode, input logic [1:0] op);
    return ((opcode == OPC_MOV) && (op == OP_MOV_REG)) ||
           ((opcode == OPC_ALU) && (op == OP_MVN));
  endfunction

  function automatic logic is_cmp(input logic [2:0] opcode, input logic [1:0] op);
    return (opcode == OPC_ALU) && (op == OP_CMP);
  endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// Moore controller that steps a register-file/ALU datapath through one
// instruction at a time; outputs depend only on state and latched fields.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic [2:0]    opcode,
  input  logic [1:0]    op,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rm,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          write,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic          illegal
);

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_opcode;
  logic [1:0]    r_op;
  logic [RW-1:0] r_rn;
  logic [RW-1:0] r_rd;
  logic [RW-1:0] r_rm;
  logic          w_start;

  assign w_start = (r_state == S_WAIT) && s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_opcode <= '0;
      r_op     <= '0;
      r_rn     <= '0;
      r_rd     <= '0;
      r_rm     <= '0;
    end else begin
      r_state <= w_state_next;
      // Fields are captured only on acceptance so later input changes are harmless.
      if (w_start) begin
        r_opcode <= opcode;
        r_op     <= op;
        r_rn     <= rn;
        r_rd     <= rd;
        r_rm     <= rm;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    illegal  = 1'b0;

    unique case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        illegal      = !is_legal(r_opcode, r_op);
        w_state_next = decode_route(r_opcode, r_op);
      end
      S_GET_A: begin
        readnum      = r_rn;
        loada        = 1'b1;
        w_state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum      = r_rm;
        loadb        = 1'b1;
        w_state_next = is_cmp(r_opcode, r_op) ? S_CMP : S_ALU;
      end
      S_ALU: begin
        loadc        = 1'b1;
        asel         = a_is_zero(r_opcode, r_op);
        w_state_next = S_WRITE_C;
      end
      S_CMP: begin
        loads        = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WRITE_C: begin
        write        = 1'b1;
        writenum     = r_rd;
        vsel         = VSEL_C;
        w_state_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        write        = 1'b1;
        writenum     = r_rn;
        vsel         = VSEL_IMM;
        w_state_next = S_WAIT;
      end
      default: w_state_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: each busy cycle of each instruction
// class is compared against a hand-written expected output vector.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic       w;
  logic [2:0] readnum, writenum;
  logic       loada, loadb, loadc, loads, write;
  logic       asel, bsel;
  logic [1:0] vsel;
  logic       illegal;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  datapath_sequencer #(.RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .opcode(opcode), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .w(w), .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .vsel(vsel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Vector layout: {w, readnum, writenum, loada, loadb, loadc, loads, write, asel, bsel, vsel, illegal}
  function automatic logic [16:0] ev(input logic ew, input logic [2:0] ern, input logic [2:0] ewn,
                                     input logic ela, input logic elb, input logic elc,
                                     input logic els, input logic ewr, input logic eas,
                                     input logic ebs, input logic [1:0] evs, input logic eil);
    return {ew, ern, ewn, ela, elb, elc, els, ewr, eas, ebs, evs, eil};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = {w, readnum, writenum, loada, loadb, loadc, loads, write, asel, bsel, vsel, illegal};
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%05h exp=%05h ok", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [16:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  // Present an instruction for one edge, then scramble the inputs to prove they were latched.
  task automatic start(input logic [2:0] opc, input logic [1:0] o,
                       input logic [2:0] a, input logic [2:0] d, input logic [2:0] m);
    s = 1'b1; opcode = opc; op = o; rn = a; rd = d; rm = m;
    @(negedge clk);
    s = 1'b0; opcode = ~opc; op = ~o; rn = ~a; rd = ~d; rm = ~m;
  endtask

  logic [16:0] IDLE, BUSY0;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    IDLE  = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    BUSY0 = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b0; s = 1'b0; opcode = '0; op = '0; rn = '0; rd = '0; rm = '0;
    #2;
    chk("reset_async", IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("wait_idle", IDLE);

    // MOV imm rn=3: DECODE, WRITE_IMM
    start(3'b110, 2'b10, 3'd3, 3'd1, 3'd2);
    chk("movi_decode", BUSY0);
    step("movi_write", ev(0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0));
    step("movi_done", IDLE);

    // ADD rn=1 rm=2 rd=5
    start(3'b101, 2'b00, 3'd1, 3'd5, 3'd2);
    chk("add_decode", BUSY0);
    step("add_get_a", ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    step("add_get_b", ev(0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    step("add_alu",   ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    step("add_write", ev(0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    step("add_done", IDLE);

    // CMP rn=4 rm=6: loads in the fourth busy cycle, never a write
    start(3'b101, 2'b01, 3'd4, 3'd3, 3'd6);
    chk("cmp_decode", BUSY0);
    step("cmp_get_a", ev(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    step("cmp_get_b", ev(0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    step("cmp_loads", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    step("cmp_done", IDLE);

    // MVN rm=7 rd=0: no GET_A, asel=1 with loadc
    start(3'b101, 2'b11, 3'd2, 3'd0, 3'd7);
    chk("mvn_decode", BUSY0);
    step("mvn_get_b", ev(0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    step("mvn_alu",   ev(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0));
    step("mvn_write", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    step("mvn_done", IDLE);

    // MOV reg rm=4 rd=6 with s held high throughout busy cycles (must be ignored)
    start(3'b110, 2'b00, 3'd1, 3'd6, 3'd4);
    s = 1'b1;
    chk("movr_decode", BUSY0);
    step("movr_get_b", ev(0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    step("movr_alu",   ev(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0));
    step("movr_write", ev(0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    step("movr_done", IDLE);
    s = 1'b0;
    step("movr_idle2", IDLE);

    // Undefined: opcode 000, then 110/01
    start(3'b000, 2'b00, 3'd5, 3'd5, 3'd5);
    chk("ill0_decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    step("ill0_done", IDLE);
    start(3'b110, 2'b01, 3'd2, 3'd2, 3'd2);
    chk("ill1_decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    step("ill1_done", IDLE);

    // Reset during GET_B of an ADD
    start(3'b101, 2'b00, 3'd1, 3'd5, 3'd2);
    chk("radd_decode", BUSY0);
    step("radd_get_a", ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    step("radd_get_b", ev(0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    #1 rst_n = 1'b0;
    s = 1'b1; opcode = 3'b110; op = 2'b10; rn = 3'd3;
    #1 chk("radd_rst_now", IDLE);
    step("radd_rst_hold", IDLE);
    rst_n = 1'b1;
    // Back-to-back MOV imm with s held high: rn=3 then rn=5
    step("b2b_decode1", BUSY0);
    rn = 3'd5;
    step("b2b_write1", ev(0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0));
    step("b2b_wait", IDLE);
    step("b2b_decode2", BUSY0);
    s = 1'b0; rn = 3'd0;
    step("b2b_write2", ev(0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0));
    step("b2b_done", IDLE);
    step("b2b_stay", IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter RW, default 3: register-index width, sized for 8 registers.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port s  input  1: start; sampled only in WAIT.
REQ-005 SHALL have port opcode  input  3: instruction class (110 MOV, 101 ALU).
REQ-006 SHALL have port op  input  2: sub-operation.
REQ-007 SHALL have ports rn, rd, rm  input  RW each: operand register indices.
REQ-008 SHALL have port w  output  1: idle/ready.
REQ-009 SHALL have port readnum  output  RW: register-file read index.
REQ-010 SHALL have port writenum  output  RW: register-file write index.
REQ-011 SHALL have ports loada, loadb, loadc, loads, write  output  1 each: load/write enables.
REQ-012 SHALL have ports asel, bsel  output  1 each: ALU operand selects (asel=1 forces A operand to 0).
REQ-013 SHALL have port vsel  output  2: write-back source (00 C result, 10 immediate; 01/11 unused, never driven).
REQ-014 SHALL have port illegal  output  1: undefined-instruction flag.

Function
REQ-015 SHALL implement a Moore FSM with states WAIT, DECODE, GET_A, GET_B, ALU, CMP, WRITE_C, WRITE_IMM; all outputs decode from state plus latched fields only.
REQ-016 SHALL, in WAIT with s=1 at an edge, latch opcode, op, rn, rd, rm and enter DECODE; inputs may change afterwards without effect.
REQ-017 SHALL ignore s in every state except WAIT.
REQ-018 SHALL route from DECODE: 110/10 (MOV imm) -> WRITE_IMM; 110/00 (MOV reg) -> GET_B; 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A; 101/11 (MVN) -> GET_B; any other combination -> WAIT.
REQ-019 SHALL drive in GET_A: readnum=rn, loada=1; then -> GET_B.
REQ-020 SHALL drive in GET_B: readnum=rm, loadb=1; then -> CMP for CMP, else -> ALU.
REQ-021 SHALL drive in ALU: loadc=1, bsel=0, asel=1 for MOV reg and MVN, else asel=0; then -> WRITE_C.
REQ-022 SHALL drive in CMP: loads=1, asel=0, bsel=0, loadc=0; then -> WAIT.
REQ-023 SHALL drive in WRITE_C: write=1, writenum=rd, vsel=00; then -> WAIT.
REQ-024 SHALL drive in WRITE_IMM: write=1, writenum=rn, vsel=10; then -> WAIT.
REQ-025 SHALL assert w=1 only in WAIT; busy cycles: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5, illegal 1.
REQ-026 SHALL assert illegal=1 for exactly the DECODE cycle of an undefined instruction; no load/write is asserted for it.
REQ-027 SHALL hold every enable not named for a state at 0, and readnum/writenum at 0 when not named.
REQ-028 SHALL assert at most one of write, loada, loadb, loadc, loads in any cycle.
REQ-029 SHALL accept a new s in the cycle after returning to WAIT (back-to-back instructions, no dead cycle beyond WAIT).

Reset
REQ-030 SHALL, on rst_n=0, immediately force WAIT, clear latched fields to 0, and drive w=1 with all other outputs 0, independent of clk.
REQ-031 SHALL abort any in-progress instruction on reset with no further write or load asserted.
REQ-032 SHALL leave WAIT no earlier than the first rising edge after rst_n deasserts with s=1.

Structure
REQ-033 SHALL place state encoding, opcode/op constants and vsel encodings in shared package dp_seq_pkg.
REQ-034 SHALL be one module with no sub-module; state register and output decode in-module.

Verification
REQ-035 SHALL test MOV imm: s=1, opcode=110, op=10, rn=3 -> one WRITE_IMM cycle with write=1, writenum=3, vsel=10; w low 2 cycles.
REQ-036 SHALL test ADD: opcode=101, op=00, rn=1, rm=2, rd=5 -> loada(readnum=1), loadb(readnum=2), loadc, write(writenum=5, vsel=00) on consecutive cycles; w low 5 cycles.
REQ-037 SHALL test CMP rn=4, rm=6 -> loads=1 in the fourth busy cycle, write never asserted.
REQ-038 SHALL test MVN rm=7, rd=0 -> no loada, asel=1 with loadc, write to 0; w low 4 cycles.
REQ-039 SHALL test illegal opcode=000 -> illegal=1 for one cycle, return to WAIT, zero enables.
REQ-040 SHALL test rst_n=0 mid-ADD (during GET_B) -> immediate WAIT, w=1, no write; then a back-to-back MOV imm pair completes correctly with s held high.
